// File: rtl/rvx_reset_conditioner.sv
// Purpose: button front-end; synchronizes and debounces a raw push-button, and stretches presses into a clean core reset.
// Latency: button_level/press_pulse follow a held input change after 2 + DEBOUNCE_CYCLES edges; reset_n_out falls one edge after press_pulse.
// Backpressure: none; there is no handshake, and presses arriving while the core is already held in reset are absorbed.
module rvx_reset_conditioner #(
   parameter int DEBOUNCE_CYCLES    = 120000,
   parameter int HOLD_CYCLES        = 16,
   parameter int BUTTON_ACTIVE_HIGH = 1
) (
   input  logic clock,
   input  logic reset_n,
   input  logic button_in,
   output logic reset_n_out,
   output logic button_level,
   output logic press_pulse
);

   // Counter widths are clamped to one bit so single-cycle settings still elaborate.
   localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

   // An active-low button is flipped before the synchronizer, so every later stage sees 1 = pressed.
   localparam logic INVERT = (BUTTON_ACTIVE_HIGH == 0) ? 1'b1 : 1'b0;

   typedef enum logic [1:0] {
      ST_ASSERT       = 2'd0,
      ST_WAIT_RELEASE = 2'd1,
      ST_RUN          = 2'd2
   } state_t;

   logic              btn_p;
   logic              sync1;
   logic              sync2;
   logic [DB_W-1:0]   db_cnt;
   logic [HOLD_W-1:0] hold_cnt;
   logic [HOLD_W-1:0] hold_cnt_nxt;
   state_t            state;
   state_t            state_nxt;
   logic              reset_n_out_nxt;

   assign btn_p = button_in ^ INVERT;

   // Two-flop synchronizer for the asynchronous button pin.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= btn_p;
         sync2 <= sync1;
      end
   end

   // Debounce: the stable level flips only after DEBOUNCE_CYCLES unbroken cycles of disagreement;
   // any return to the stable value throws away the partial count.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         db_cnt       <= '0;
         button_level <= 1'b0;
         press_pulse  <= 1'b0;
      end else begin
         press_pulse <= 1'b0;
         if (sync2 == button_level) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            button_level <= sync2;
            db_cnt       <= '0;
            // Only the rising flip is a press; a release flips the level silently.
            press_pulse  <= sync2;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

   // Reset sequencer state, hold counter and registered core reset.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state       <= ST_ASSERT;
         hold_cnt    <= '0;
         reset_n_out <= 1'b0;
      end else begin
         state       <= state_nxt;
         hold_cnt    <= hold_cnt_nxt;
         reset_n_out <= reset_n_out_nxt;
      end
   end

   // Next-state logic: hold the core in reset for the minimum width, then until the button is let go.
   always_comb begin
      state_nxt    = state;
      hold_cnt_nxt = hold_cnt;
      unique case (state)
         ST_ASSERT: begin
            // Presses seen here are ignored so they cannot restart the hold count.
            if (hold_cnt == HOLD_LAST) begin
               hold_cnt_nxt = '0;
               state_nxt    = button_level ? ST_WAIT_RELEASE : ST_RUN;
            end else begin
               hold_cnt_nxt = hold_cnt + 1'b1;
            end
         end
         ST_WAIT_RELEASE: begin
            if (!button_level) begin
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (press_pulse) begin
               state_nxt    = ST_ASSERT;
               hold_cnt_nxt = '0;
            end
         end
         default: begin
            state_nxt    = ST_ASSERT;
            hold_cnt_nxt = '0;
         end
      endcase
      // The core runs only in RUN; registering the decoded next state keeps reset_n_out glitch-free.
      reset_n_out_nxt = (state_nxt == ST_RUN);
   end

endmodule
